// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: FSM states,
// opcode/funct encodings, ALU operations and the instruction decoder.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLTU = 3'd5,
    ALU_LUI  = 3'd6
  } alu_op_e;

  typedef enum logic [3:0] {
    IC_ALU_R   = 4'd0,
    IC_ALU_I   = 4'd1,
    IC_LW      = 4'd2,
    IC_SW      = 4'd3,
    IC_BEQ     = 4'd4,
    IC_BNE     = 4'd5,
    IC_J       = 4'd6,
    IC_JAL     = 4'd7,
    IC_JR      = 4'd8,
    IC_SYSCALL = 4'd9,
    IC_UNDEF   = 4'd10
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    alu_op_e alu;
  } dec_t;

  // R-type arithmetic requires a zero shamt field; anything else is undefined.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.cls = IC_UNDEF;
    d.alu = ALU_ADD;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          FN_ADDU: if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_ADD;  end
          FN_SUBU: if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_SUB;  end
          FN_AND:  if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_AND;  end
          FN_OR:   if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_OR;   end
          FN_SLT:  if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_SLT;  end
          FN_SLTU: if (ir[10:6] == 5'd0) begin d.cls = IC_ALU_R; d.alu = ALU_SLTU; end
          FN_JR:      d.cls = IC_JR;
          FN_SYSCALL: d.cls = IC_SYSCALL;
          default:    d.cls = IC_UNDEF;
        endcase
      end
      OP_ORI:  begin d.cls = IC_ALU_I; d.alu = ALU_OR;  end
      OP_LUI:  begin d.cls = IC_ALU_I; d.alu = ALU_LUI; end
      OP_LW:   d.cls = IC_LW;
      OP_SW:   d.cls = IC_SW;
      OP_BEQ:  d.cls = IC_BEQ;
      OP_BNE:  d.cls = IC_BNE;
      OP_J:    d.cls = IC_J;
      OP_JAL:  d.cls = IC_JAL;
      default: d.cls = IC_UNDEF;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// General-purpose register file: NREG x 32, two asynchronous reads, one
// synchronous write; register 0 is hard-wired to zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int unsigned NREG = 32,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [RW-1:0] raddr1_i,
  output logic [31:0]   rdata1_o,
  input  logic [RW-1:0] raddr2_i,
  output logic [31:0]   rdata2_o
);

  logic [31:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core sharing one memory port for fetch and data.
// Define MC_DATAPATH_ILLEGAL_EN to halt (illegal=1) on undefined encodings.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned NREG     = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned       RW        = $clog2(NREG);
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_PC);
  localparam logic [RW-1:0]     LINK_REG  = RW'(NREG - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       res_q, res_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  dec_t              dec;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx;
  logic [31:0]       rf_rdata1, rf_rdata2;
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [31:0]       rf_wdata;

  logic [31:0]       imm_sext, imm_zext, br_off, alu_b, alu_y, ea;
  logic [ADDR_W-1:0] pc4, br_tgt, jmp_tgt, ea_addr;

  assign dec    = decode(ir_q);
  assign rs_idx = ir_q[21 +: RW];
  assign rt_idx = ir_q[16 +: RW];
  assign rd_idx = ir_q[11 +: RW];

  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0000, ir_q[15:0]};
  assign br_off   = {imm_sext[29:0], 2'b00};

  assign pc4     = pc_q + ADDR_W'(4);
  assign br_tgt  = pc4 + ADDR_W'($signed(br_off));
  // Keep the top four bits of PC+4 and splice in the 26-bit word index.
  assign jmp_tgt = (pc4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir_q[25:0], 2'b00});

  assign ea      = a_q + imm_sext;
  assign ea_addr = ADDR_W'({ea[31:2], 2'b00});

  assign alu_b = (dec.cls == IC_ALU_I) ? imm_zext : b_q;
  assign alu_y = alu(dec.alu, a_q, alu_b);

  mc_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs_idx),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rt_idx),
    .rdata2_o (rf_rdata2)
  );

  // Memory port is driven purely from registered state, so it holds during stalls.
  assign mem_req   = !reset && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_we    = (state_q == ST_MEM) && (dec.cls == IC_SW);
  assign mem_addr  = (state_q == ST_MEM) ? ea_addr : pc_q;
  assign mem_wdata = b_q;

  assign pc_out  = pc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if ((state_q == ST_EXEC) && (dec.cls == IC_JAL)) begin
      rf_we    = 1'b1;
      rf_waddr = LINK_REG;
      rf_wdata = 32'(pc4);
    end else if (state_q == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = (dec.cls == IC_ALU_R) ? rd_idx : rt_idx;
      rf_wdata = res_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rf_rdata1;
        b_d = rf_rdata2;
        if (dec.cls == IC_SYSCALL) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (dec.cls == IC_UNDEF) begin
`ifdef MC_DATAPATH_ILLEGAL_EN
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
`else
          pc_d    = pc4;
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d = alu_y;
        case (dec.cls)
          IC_BEQ: begin
            pc_d    = (a_q == b_q) ? br_tgt : pc4;
            state_d = ST_FETCH;
          end
          IC_BNE: begin
            pc_d    = (a_q != b_q) ? br_tgt : pc4;
            state_d = ST_FETCH;
          end
          IC_J, IC_JAL: begin
            pc_d    = jmp_tgt;
            state_d = ST_FETCH;
          end
          IC_JR: begin
            pc_d    = ADDR_W'(a_q);
            state_d = ST_FETCH;
          end
          IC_LW, IC_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (dec.cls == IC_SW) begin
            pc_d    = pc4;
            state_d = ST_FETCH;
          end else begin
            res_d   = mem_rdata;
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc4;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a table of instructions with expected
// latency, next PC and store traffic, plus stall/halt/reset sequences.
module tb_mc_datapath;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        halted, illegal;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  int unsigned wr_cnt;
  logic [31:0] last_waddr, last_wdata;
  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned cycles;
    logic [31:0] npc;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int unsigned stall;
  } vec_t;

  vec_t vecs [29];

  mc_datapath #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_3000),
    .NREG     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .pc_out    (pc_out),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:12] == 20'h00003) ? imem[mem_addr[11:2]]
                                                    : dmem[mem_addr[11:2]];

  initial begin
    wr_cnt     = 0;
    last_waddr = '0;
    last_wdata = '0;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      dmem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt               <= wr_cnt + 1;
      last_waddr           <= mem_addr;
      last_wdata           <= mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input int unsigned cyc, input logic [31:0] npc,
                              input logic wr, input logic [31:0] wa,
                              input logic [31:0] wd, input int unsigned stall);
    vec_t v;
    v.pc = pc; v.instr = instr; v.cycles = cyc; v.npc = npc;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.stall = stall;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    tick();
    chk("rst_pc", pc_out, 32'h0000_3000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_mem_req_hold", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_fetch_addr", mem_addr, 32'h0000_3000);
    chk("rst_fetch_req", {31'd0, mem_req}, 32'd1);
  endtask

  // Entered at the sampling point of a FETCH cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int unsigned wc0;
    wc0 = wr_cnt;
    imem[v.pc[11:2]] = v.instr;
    mem_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_pc", idx), pc_out, v.pc);
    chk($sformatf("v%0d_fetch_req", idx), {31'd0, mem_req}, 32'd1);
    chk($sformatf("v%0d_fetch_we", idx), {31'd0, mem_we}, 32'd0);
    chk($sformatf("v%0d_fetch_addr", idx), mem_addr, v.pc);
    if (v.stall > 0) begin
      mem_ready = 1'b0;
      for (int unsigned s = 0; s < v.stall; s++) begin
        tick();
        chk($sformatf("v%0d_stall%0d_req", idx, s), {31'd0, mem_req}, 32'd1);
        chk($sformatf("v%0d_stall%0d_addr", idx, s), mem_addr, v.pc);
        chk($sformatf("v%0d_stall%0d_pc", idx, s), pc_out, v.pc);
      end
      mem_ready = 1'b1;
    end
    for (int unsigned c = 1; c < v.cycles; c++) tick();
    chk($sformatf("v%0d_pc_early", idx), pc_out, v.pc);
    tick();
    chk($sformatf("v%0d_npc", idx), pc_out, v.npc);
    if (v.wr) begin
      chk($sformatf("v%0d_wr_cnt", idx), wr_cnt, wc0 + 1);
      chk($sformatf("v%0d_wr_addr", idx), last_waddr, v.waddr);
      chk($sformatf("v%0d_wr_data", idx), last_wdata, v.wdata);
    end else begin
      chk($sformatf("v%0d_no_wr", idx), wr_cnt, wc0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;

    vecs[0]  = mk(32'h3000, 32'h3401_1234, 4, 32'h3004, 1'b0, 32'h0,  32'h0,        5); // ori $1,$0,0x1234
    vecs[1]  = mk(32'h3004, 32'hAC01_0004, 4, 32'h3008, 1'b1, 32'h4,  32'h1234,     0); // sw $1,4($0)
    vecs[2]  = mk(32'h3008, 32'h8C02_0004, 5, 32'h300C, 1'b0, 32'h0,  32'h0,        0); // lw $2,4($0)
    vecs[3]  = mk(32'h300C, 32'hAC02_0008, 4, 32'h3010, 1'b1, 32'h8,  32'h1234,     0); // sw $2,8($0)
    vecs[4]  = mk(32'h3010, 32'h1000_FFFF, 3, 32'h3010, 1'b0, 32'h0,  32'h0,        0); // beq $0,$0,-1
    vecs[5]  = mk(32'h3010, 32'h1400_FFFF, 3, 32'h3014, 1'b0, 32'h0,  32'h0,        0); // bne $0,$0,-1
    vecs[6]  = mk(32'h3014, 32'h3C03_8000, 4, 32'h3018, 1'b0, 32'h0,  32'h0,        0); // lui $3,0x8000
    vecs[7]  = mk(32'h3018, 32'h0061_202A, 4, 32'h301C, 1'b0, 32'h0,  32'h0,        0); // slt $4,$3,$1
    vecs[8]  = mk(32'h301C, 32'h0061_282B, 4, 32'h3020, 1'b0, 32'h0,  32'h0,        0); // sltu $5,$3,$1
    vecs[9]  = mk(32'h3020, 32'h0001_3023, 4, 32'h3024, 1'b0, 32'h0,  32'h0,        0); // subu $6,$0,$1
    vecs[10] = mk(32'h3024, 32'h0021_0021, 4, 32'h3028, 1'b0, 32'h0,  32'h0,        0); // addu $0,$1,$1
    vecs[11] = mk(32'h3028, 32'h00C1_3824, 4, 32'h302C, 1'b0, 32'h0,  32'h0,        0); // and $7,$6,$1
    vecs[12] = mk(32'h302C, 32'h0064_4025, 4, 32'h3030, 1'b0, 32'h0,  32'h0,        0); // or $8,$3,$4
    vecs[13] = mk(32'h3030, 32'hAC04_0010, 4, 32'h3034, 1'b1, 32'h10, 32'h1,        0);
    vecs[14] = mk(32'h3034, 32'hAC05_0014, 4, 32'h3038, 1'b1, 32'h14, 32'h0,        0);
    vecs[15] = mk(32'h3038, 32'hAC06_0018, 4, 32'h303C, 1'b1, 32'h18, 32'hFFFF_EDCC, 0);
    vecs[16] = mk(32'h303C, 32'hAC00_001C, 4, 32'h3040, 1'b1, 32'h1C, 32'h0,        0);
    vecs[17] = mk(32'h3040, 32'hAC07_0020, 4, 32'h3044, 1'b1, 32'h20, 32'h4,        0);
    vecs[18] = mk(32'h3044, 32'hAC08_0024, 4, 32'h3048, 1'b1, 32'h24, 32'h8000_0001, 0);
    vecs[19] = mk(32'h3048, 32'hAC03_FFFC, 4, 32'h304C, 1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 0);
    vecs[20] = mk(32'h304C, 32'h0C00_0C00, 3, 32'h3000, 1'b0, 32'h0,  32'h0,        0); // jal 0x0C00
    vecs[21] = mk(32'h3000, 32'hAC1F_0028, 4, 32'h3004, 1'b1, 32'h28, 32'h3050,     0); // sw $31
    vecs[22] = mk(32'h3004, 32'h0800_0C40, 3, 32'h3100, 1'b0, 32'h0,  32'h0,        0); // j 0x3100
    vecs[23] = mk(32'h3100, 32'h3409_3200, 4, 32'h3104, 1'b0, 32'h0,  32'h0,        0); // ori $9
    vecs[24] = mk(32'h3104, 32'h0120_0008, 3, 32'h3200, 1'b0, 32'h0,  32'h0,        0); // jr $9
    vecs[25] = mk(32'h3200, 32'h1022_0002, 3, 32'h320C, 1'b0, 32'h0,  32'h0,        0); // beq $1,$2,+2
    vecs[26] = mk(32'h320C, 32'h1423_FFFD, 3, 32'h3204, 1'b0, 32'h0,  32'h0,        0); // bne $1,$3,-3
    vecs[27] = mk(32'h3204, 32'h8C0A_0018, 5, 32'h3208, 1'b0, 32'h0,  32'h0,        0); // lw $10,0x18
    vecs[28] = mk(32'h3208, 32'hAC0A_002C, 4, 32'h320C, 1'b1, 32'h2C, 32'hFFFF_EDCC, 0);

    do_reset();
    for (int i = 0; i < 29; i++) run_vec(i, vecs[i]);

    // Store held off in MEM: address/data/we must not move.
    imem[10'h083] = 32'hAC01_0030;
    mem_ready = 1'b1;
    begin
      int unsigned wc0;
      wc0 = wr_cnt;
      #1;
      chk("mstall_fetch_addr", mem_addr, 32'h320C);
      tick();
      chk("mstall_decode_req", {31'd0, mem_req}, 32'd0);
      mem_ready = 1'b0;
      tick();
      chk("mstall_exec_req", {31'd0, mem_req}, 32'd0);
      tick();
      for (int unsigned s = 0; s < 4; s++) begin
        chk($sformatf("mstall%0d_req", s), {31'd0, mem_req}, 32'd1);
        chk($sformatf("mstall%0d_we", s), {31'd0, mem_we}, 32'd1);
        chk($sformatf("mstall%0d_addr", s), mem_addr, 32'h30);
        chk($sformatf("mstall%0d_wdata", s), mem_wdata, 32'h1234);
        chk($sformatf("mstall%0d_nowr", s), wr_cnt, wc0);
        if (s < 3) tick();
      end
      mem_ready = 1'b1;
      tick();
      chk("mstall_wr_cnt", wr_cnt, wc0 + 1);
      chk("mstall_wr_data", last_wdata, 32'h1234);
      chk("mstall_npc", pc_out, 32'h3210);
    end

    // syscall halts and stays halted.
    imem[10'h084] = 32'h0000_000C;
    tick();
    tick();
    chk("sys_halted", {31'd0, halted}, 32'd1);
    chk("sys_illegal", {31'd0, illegal}, 32'd0);
    chk("sys_req", {31'd0, mem_req}, 32'd0);
    chk("sys_pc", pc_out, 32'h3210);
    repeat (3) tick();
    chk("sys_halted_hold", {31'd0, halted}, 32'd1);
    chk("sys_req_hold", {31'd0, mem_req}, 32'd0);
    chk("sys_pc_hold", pc_out, 32'h3210);

    // Undefined opcode 0x3F.
    do_reset();
    imem[10'h000] = 32'hFC00_0000;
    tick();
    tick();
`ifdef MC_DATAPATH_ILLEGAL_EN
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_illegal", {31'd0, illegal}, 32'd1);
    chk("ill_pc", pc_out, 32'h3000);
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    repeat (2) tick();
    chk("ill_req_hold", {31'd0, mem_req}, 32'd0);
    chk("ill_halted_hold", {31'd0, halted}, 32'd1);
`else
    chk("ill_pc", pc_out, 32'h3004);
    chk("ill_illegal", {31'd0, illegal}, 32'd0);
    chk("ill_halted", {31'd0, halted}, 32'd0);
    chk("ill_req", {31'd0, mem_req}, 32'd1);
    chk("ill_addr", mem_addr, 32'h3004);
`endif

    // Reset during an accepted fetch of a jump: the fetch is abandoned.
    do_reset();
    run_vec(100, mk(32'h3000, 32'h3401_1234, 4, 32'h3004, 1'b0, 32'h0, 32'h0, 0));
    imem[10'h001] = 32'h0800_0C40;
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_pc", pc_out, 32'h3000);
    chk("midrst_req_after", {31'd0, mem_req}, 32'd1);
    chk("midrst_addr", mem_addr, 32'h3000);
    tick();
    chk("midrst_decode_req", {31'd0, mem_req}, 32'd0);
    repeat (3) tick();
    chk("midrst_ori_pc", pc_out, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
